// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encodings,
// datapath width, canonical NOP and default reset PC / PC increment.
package fetch_sequencer_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int              PC_STEP_DEFAULT  = 4;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_FETCH = 2'd1;
    localparam logic [1:0] FS_HOLD  = 2'd2;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select for the fetch sequencer.
// Priority: reset, branch redirect, sequential advance, hold.
module fetch_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            reset,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_addr,
    input  logic            advance,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        // NOTE: assigning a default before the if-chain guarantees every path
        // drives pc_next, so no latch is inferred.
        pc_next = pc;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (branch) begin
            pc_next = {branch_addr[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the imem handshake,
// handles stall/branch/squash. Optional counters under FETCH_SEQ_PERF_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            go,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_addr,
    input  logic [5:0]      do_stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            read_enable_cpu
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
    output logic [15:0]     perf_flush_cnt
`endif
);

    logic [1:0]      state, state_next;
    logic            squash;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] pc_next;
    logic            ack_seen, advance, discard, stall;
    logic            unused_stall_bits;

    assign stall             = do_stall[0];
    assign unused_stall_bits = ^do_stall[5:1];

    assign imem_req        = (state == FS_FETCH);
    assign read_enable_cpu = imem_req;
    // addr_q holds the outstanding request address; it differs from pc only
    // while a squashed request drains after a redirect.
    assign imem_addr       = addr_q;

    assign ack_seen = imem_req && imem_ack;
    assign advance  = ack_seen && !squash && !branch;
    assign discard  = ack_seen && (squash || branch);

    fetch_pc_next #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_next (
        .reset       (reset),
        .branch      (branch),
        .branch_addr (branch_addr),
        .advance     (advance),
        .pc          (pc),
        .pc_next     (pc_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            FS_IDLE:  if (go) state_next = FS_FETCH;
            FS_FETCH: begin
                if (imem_ack) begin
                    if (advance && stall) state_next = FS_HOLD;
                    else if (go)          state_next = FS_FETCH;
                    else                  state_next = FS_IDLE;
                end
            end
            FS_HOLD: begin
                if (branch)      state_next = FS_FETCH;
                else if (!stall) state_next = go ? FS_FETCH : FS_IDLE;
            end
            default:  state_next = FS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_IDLE;
            pc          <= RESET_PC;
            addr_q      <= RESET_PC;
            squash      <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (!(imem_req && !imem_ack)) addr_q <= pc_next;
            if (imem_req) squash <= imem_ack ? 1'b0 : (squash || branch);
            if (advance) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= addr_q;
            end else if (!(state == FS_HOLD && state_next == FS_HOLD)) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (advance && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == FS_HOLD && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((discard || (state == FS_HOLD && branch)) && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, go, branch, imem_ack;
    logic [31:0] branch_addr;
    logic [5:0]  do_stall;
    logic        imem_req, instr_valid, read_enable_cpu;
    logic [31:0] imem_addr, imem_rdata, pc, instr, instr_pc;

    logic        reset2, go2, imem_ack2;
    logic        imem_req2, instr_valid2, read_enable_cpu2;
    logic [31:0] imem_addr2, imem_rdata2, pc2, instr2, instr_pc2;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] pf1, ps1, pf2, ps2;
    logic [15:0] pl1, pl2;
`endif

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .go(go), .branch(branch), .branch_addr(branch_addr),
        .do_stall(do_stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .read_enable_cpu(read_enable_cpu)
`ifdef FETCH_SEQ_PERF_EN
        , .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1), .perf_flush_cnt(pl1)
`endif
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .go(go2), .branch(1'b0), .branch_addr(32'h0),
        .do_stall(6'h0), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
        .imem_rdata(imem_rdata2), .pc(pc2), .instr_valid(instr_valid2), .instr(instr2),
        .instr_pc(instr_pc2), .read_enable_cpu(read_enable_cpu2)
`ifdef FETCH_SEQ_PERF_EN
        , .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2), .perf_flush_cnt(pl2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; branch = 1'b0; branch_addr = '0; do_stall = '0; imem_ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (imem_req !== 1'b0) begin n_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if (read_enable_cpu !== 1'b0) begin n_failed++; $display("FAIL reset_rd_en: got %b want 0", read_enable_cpu); end
        n_tests++; if (pc !== 32'h0) begin n_failed++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_failed++; $display("FAIL reset_instr: valid=%b instr=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        go = 1'b1; imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_failed++; $display("FAIL zw_addr%0d: req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k)); end
            if (k > 0) begin
                n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 1)) || instr !== mem_word(32'(4 * (k - 1)))) begin
                    n_failed++; $display("FAIL zw_valid%0d: valid=%b ipc=%h instr=%h want 1/%h/%h", k, instr_valid,
                                         instr_pc, instr, 32'(4 * (k - 1)), mem_word(32'(4 * (k - 1)))); end
            end
        end
        go = 1'b0;
        tick();
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || imem_req !== 1'b0 || pc !== 32'h10) begin
            n_failed++; $display("FAIL zw_last: valid=%b ipc=%h req=%b pc=%h want 1/c/0/10", instr_valid, instr_pc, imem_req, pc); end
        imem_ack = 1'b0;
        tick();
        n_tests++; if (instr_valid !== 1'b0) begin n_failed++; $display("FAIL zw_pulse: valid=%b want 0", instr_valid); end
    endtask

    task automatic test_wait_ack();
        do_reset();
        go = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                n_failed++; $display("FAIL wait_stable%0d: req=%b addr=%h valid=%b want 1/0/0", k, imem_req, imem_addr, instr_valid); end
        end
        go = 1'b0; imem_ack = 1'b1;
        tick();
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0) || imem_req !== 1'b0) begin
            n_failed++; $display("FAIL wait_done: valid=%b ipc=%h instr=%h req=%b want 1/0/%h/0", instr_valid, instr_pc, instr, mem_word(32'h0), imem_req); end
        imem_ack = 1'b0;
        tick();
        n_tests++; if (instr_valid !== 1'b0) begin n_failed++; $display("FAIL wait_single: valid=%b want 0", instr_valid); end
    endtask

    task automatic test_branch_squash();
        do_reset();
        go = 1'b1;
        tick();
        branch = 1'b1; branch_addr = 32'h103;
        tick();
        n_tests++; if (pc !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_failed++; $display("FAIL br_wait: pc=%h req=%b addr=%h valid=%b want 100/1/0/0", pc, imem_req, imem_addr, instr_valid); end
        branch = 1'b0; imem_ack = 1'b1;
        tick();
        n_tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_failed++; $display("FAIL br_drop: valid=%b req=%b addr=%h want 0/1/100", instr_valid, imem_req, imem_addr); end
        go = 1'b0;
        tick();
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100) || pc !== 32'h104) begin
            n_failed++; $display("FAIL br_target: valid=%b ipc=%h instr=%h pc=%h want 1/100/%h/104", instr_valid, instr_pc, instr, mem_word(32'h100), pc); end
        imem_ack = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        go = 1'b1; imem_ack = 1'b1;
        tick();
        do_stall = 6'b000001;
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0 || pc !== 32'h4) begin
                n_failed++; $display("FAIL stall_hold%0d: valid=%b ipc=%h req=%b pc=%h want 1/0/0/4", k, instr_valid, instr_pc, imem_req, pc); end
            if (k < 3) tick();
        end
        do_stall = 6'b111110;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            n_failed++; $display("FAIL stall_resume: req=%b addr=%h valid=%b want 1/4/0", imem_req, imem_addr, instr_valid); end
        do_stall = '0;
    endtask

    task automatic test_wrap();
        reset2 = 1'b1; go2 = 1'b0; imem_ack2 = 1'b0;
        tick();
        reset2 = 1'b0;
        n_tests++; if (pc2 !== 32'hFFFF_FFFC) begin n_failed++; $display("FAIL wrap_reset_pc: got %h want fffffffc", pc2); end
        go2 = 1'b1; imem_ack2 = 1'b1;
        tick();
        n_tests++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin
            n_failed++; $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
        go2 = 1'b0;
        tick();
        n_tests++; if (pc2 !== 32'h0 || instr_valid2 !== 1'b1 || instr_pc2 !== 32'hFFFF_FFFC) begin
            n_failed++; $display("FAIL wrap_pc: pc=%h valid=%b ipc=%h want 0/1/fffffffc", pc2, instr_valid2, instr_pc2); end
        imem_ack2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        go = 1'b1; branch = 1'b1; branch_addr = 32'h40;
        tick();
        branch = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_failed++; $display("FAIL rst_mid: req=%b pc=%h valid=%b want 0/0/0", imem_req, pc, instr_valid); end
        reset = 1'b0; go = 1'b0; imem_ack = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
            n_failed++; $display("FAIL rst_stale_ack: req=%b valid=%b pc=%h want 0/0/0", imem_req, instr_valid, pc); end
        imem_ack = 1'b0;
    endtask

    // Model tracks what the fetch unit is doing in terms of transactions:
    // a request in flight (maybe to be discarded), or an instruction parked for decode.
    task automatic test_random();
        bit          m_busy = 0, m_squash = 0, m_hold = 0, m_valid = 0, accepted;
        logic [31:0] m_pc = 0, m_addr = 0, m_ins = 0, m_ipc = 0, tgt;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            go          = ($urandom_range(0, 3) != 0);
            branch      = ($urandom_range(0, 9) == 0);
            branch_addr = $urandom;
            do_stall    = 6'($urandom_range(0, 63)) & (($urandom_range(0, 2) == 0) ? 6'h3F : 6'h3E);
            imem_ack    = ($urandom_range(0, 1) == 1);

            if (reset) begin
                m_busy = 0; m_squash = 0; m_hold = 0; m_valid = 0;
                m_pc = 0; m_addr = 0; m_ins = 0; m_ipc = 0;
            end else begin
                tgt = branch_addr & ~32'h3;
                if (m_busy) begin
                    if (imem_ack) begin
                        accepted = !m_squash && !branch;
                        m_valid  = accepted;
                        if (accepted) begin m_ins = mem_word(m_addr); m_ipc = m_addr; m_pc = m_pc + 32'd4; end
                        if (branch) m_pc = tgt;
                        m_squash = 0;
                        if (accepted && do_stall[0]) begin m_busy = 0; m_hold = 1; end
                        else begin m_busy = go; m_addr = m_pc; end
                    end else begin
                        m_valid = 0;
                        if (branch) begin m_pc = tgt; m_squash = 1; end
                    end
                end else if (m_hold) begin
                    if (branch) begin m_pc = tgt; m_valid = 0; m_hold = 0; m_busy = 1; m_addr = m_pc; end
                    else if (!do_stall[0]) begin m_hold = 0; m_valid = 0; m_busy = go; m_addr = m_pc; end
                end else begin
                    m_valid = 0;
                    if (branch) m_pc = tgt;
                    if (go) begin m_busy = 1; m_addr = m_pc; end
                end
            end

            tick();
            n_tests++;
            if (imem_req !== m_busy || read_enable_cpu !== m_busy || pc !== m_pc || instr_valid !== m_valid ||
                (m_busy && imem_addr !== m_addr) || (m_valid && (instr !== m_ins || instr_pc !== m_ipc))) begin
                n_failed++;
                $display("FAIL random cyc%0d: req=%b/%b pc=%h/%h addr=%h/%h valid=%b/%b instr=%h/%h ipc=%h/%h (got/want)",
                         c, imem_req, m_busy, pc, m_pc, imem_addr, m_addr, instr_valid, m_valid, instr, m_ins, instr_pc, m_ipc);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; branch = 1'b0; branch_addr = '0; do_stall = '0; imem_ack = 1'b0;
        reset2 = 1'b1; go2 = 1'b0; imem_ack2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait_ack();
        test_branch_squash();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
